// File: rtl/c3aibadapt_avmm2_initiator.sv
// ---------------------------------------------------------------------------
// c3aibadapt_avmm2_initiator
//
// Initiator end of the remote AVMM2 configuration path. The block sits on the
// fabric/PLD side. It turns local Avalon-MM style reads and writes into
// single-cycle remote_pld_avmm_* request pulses toward the far-side config
// bridge. Only one transaction is outstanding at a time, and waitrequest
// holds off new commands until the current one completes.
//
// Optional feature macro: C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
//   Defined   : WAIT_BUSY / WAIT_RDV are bounded by TIMEOUT_CYCLES. On expiry,
//               pld_avmm2_timeout pulses. A timed-out read also returns
//               ERR_DATA with a readdatavalid pulse.
//   Undefined : the wait states wait indefinitely, and pld_avmm2_timeout is
//               tied to 0.
//
// Ports
//   avmm_clock_dprio_clk          in   1  block clock
//   avmm_reset_avmm_rst_n         in   1  asynchronous active-low reset
//   pld_avmm2_read                in   1  local read command
//   pld_avmm2_write               in   1  local write command
//   pld_avmm2_reg_addr            in   9  local register address
//   pld_avmm2_writedata           in   8  local write data
//   pld_avmm2_waitrequest         out  1  high = command not accepted
//   pld_avmm2_readdata            out  8  returned read data (held)
//   pld_avmm2_readdatavalid       out  1  one-cycle read-return strobe
//   pld_avmm2_timeout             out  1  one-cycle timeout strobe
//   remote_pld_avmm_read          out  1  remote read pulse
//   remote_pld_avmm_write         out  1  remote write pulse
//   remote_pld_avmm_request       out  1  remote request pulse
//   remote_pld_avmm_reg_addr      out  9  latched address
//   remote_pld_avmm_writedata     out  8  latched write data
//   remote_pld_avmm_busy          in   1  far side busy
//   remote_pld_avmm_readdata      in   8  far side read data
//   remote_pld_avmm_readdatavalid in   1  far side read-return strobe
// ---------------------------------------------------------------------------
module c3aibadapt_avmm2_initiator #(
    parameter int unsigned WR_SETTLE      = 2,     // 1..15
    parameter int unsigned TIMEOUT_CYCLES = 255,   // 1..255
    parameter logic [7:0]  ERR_DATA       = 8'hEE
) (
    input  logic       avmm_clock_dprio_clk,
    input  logic       avmm_reset_avmm_rst_n,
    input  logic       pld_avmm2_read,
    input  logic       pld_avmm2_write,
    input  logic [8:0] pld_avmm2_reg_addr,
    input  logic [7:0] pld_avmm2_writedata,
    output logic       pld_avmm2_waitrequest,
    output logic [7:0] pld_avmm2_readdata,
    output logic       pld_avmm2_readdatavalid,
    output logic       pld_avmm2_timeout,
    output logic       remote_pld_avmm_read,
    output logic       remote_pld_avmm_write,
    output logic       remote_pld_avmm_request,
    output logic [8:0] remote_pld_avmm_reg_addr,
    output logic [7:0] remote_pld_avmm_writedata,
    input  logic       remote_pld_avmm_busy,
    input  logic [7:0] remote_pld_avmm_readdata,
    input  logic       remote_pld_avmm_readdatavalid
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_RDV  = 2'd3
    } state_t;

    localparam logic [3:0] LP_SETTLE = 4'(WR_SETTLE);

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_remote_read;
    logic       r_remote_write;
    logic       r_remote_request;
    logic [8:0] r_remote_addr;
    logic [7:0] r_remote_wdata;
    logic       r_rdv;
    logic [7:0] r_rdata;
    logic [3:0] r_settle_cnt;

    logic       w_accept;
    logic       w_read_nxt;
    logic       w_write_nxt;
    logic       w_request_nxt;
    logic       w_rdv_nxt;
    logic [7:0] w_rdata_nxt;
    logic [3:0] w_settle_nxt;

`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
    localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_to_cnt;
    logic       r_timeout;
    logic [7:0] w_to_nxt;
    logic       w_timeout_nxt;
    logic       w_to_hit;

    // The cycle in which the count equals TIMEOUT_CYCLES-1 is the last of the
    // TIMEOUT_CYCLES cycles allowed in a wait state.
    assign w_to_hit = (r_to_cnt == LP_TO_LAST);
`else
    // These parameters only matter when the timeout feature is built in.
    logic w_unused_cfg;
    assign w_unused_cfg = ^{ERR_DATA, 8'(TIMEOUT_CYCLES)};
`endif

    // Combinational so that a far-side busy blocks acceptance in the same cycle.
    assign pld_avmm2_waitrequest = (r_state != ST_IDLE) | remote_pld_avmm_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // pre-edge values, whatever order the always blocks run in.
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        w_read_nxt    = 1'b0;
        w_write_nxt   = 1'b0;
        w_request_nxt = 1'b0;
        w_rdv_nxt     = 1'b0;
        w_rdata_nxt   = r_rdata;
        w_settle_nxt  = r_settle_cnt;
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
        w_to_nxt      = r_to_cnt;
        w_timeout_nxt = 1'b0;
`endif

        unique case (r_state)
            ST_IDLE: begin
                // waitrequest reduces to busy in IDLE. Read wins over write.
                if ((pld_avmm2_read | pld_avmm2_write) & !remote_pld_avmm_busy) begin
                    w_accept      = 1'b1;
                    w_state_nxt   = ST_ISSUE;
                    w_request_nxt = 1'b1;
                    w_read_nxt    = pld_avmm2_read;
                    w_write_nxt   = !pld_avmm2_read;
                end
            end

            ST_ISSUE: begin
                // The remote strobes are high during exactly this one cycle.
                w_settle_nxt = '0;
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                w_to_nxt     = '0;
`endif
                w_state_nxt  = r_remote_read ? ST_WAIT_RDV : ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                w_to_nxt = r_to_cnt + 8'd1;
`endif
                // The far side needs a few cycles to raise busy after a write.
                // Busy is ignored until the settle count is exhausted.
                if (r_settle_cnt != LP_SETTLE) begin
                    w_settle_nxt = r_settle_cnt + 4'd1;
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                    if (w_to_hit) begin
                        w_state_nxt   = ST_IDLE;
                        w_timeout_nxt = 1'b1;
                    end
`endif
                end else if (!remote_pld_avmm_busy) begin
                    w_state_nxt = ST_IDLE;
                end
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_state_nxt   = ST_IDLE;
                    w_timeout_nxt = 1'b1;
                end
`endif
            end

            ST_WAIT_RDV: begin
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                w_to_nxt = r_to_cnt + 8'd1;
`endif
                // A real return beats a coincident timeout.
                if (remote_pld_avmm_readdatavalid) begin
                    w_rdata_nxt = remote_pld_avmm_readdata;
                    w_rdv_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
                else if (w_to_hit) begin
                    w_rdata_nxt   = ERR_DATA;
                    w_rdv_nxt     = 1'b1;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end
`endif
            end

            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs, latched command and counters
    // ------------------------------------------------------------------
    // NOTE: all of these are plain flops, not a memory, so each one takes the
    // reset and the interface comes out of reset in a known state.
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            r_remote_read    <= 1'b0;
            r_remote_write   <= 1'b0;
            r_remote_request <= 1'b0;
            r_remote_addr    <= '0;
            r_remote_wdata   <= '0;
            r_rdv            <= 1'b0;
            r_rdata          <= '0;
            r_settle_cnt     <= '0;
        end else begin
            r_remote_read    <= w_read_nxt;
            r_remote_write   <= w_write_nxt;
            r_remote_request <= w_request_nxt;
            r_rdv            <= w_rdv_nxt;
            r_rdata          <= w_rdata_nxt;
            r_settle_cnt     <= w_settle_nxt;
            if (w_accept) begin
                r_remote_addr  <= pld_avmm2_reg_addr;
                r_remote_wdata <= pld_avmm2_writedata;
            end
        end
    end

`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
    always_ff @(posedge avmm_clock_dprio_clk or negedge avmm_reset_avmm_rst_n) begin
        if (!avmm_reset_avmm_rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_to_cnt  <= w_to_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign pld_avmm2_timeout = r_timeout;
`else
    assign pld_avmm2_timeout = 1'b0;
`endif

    assign remote_pld_avmm_read      = r_remote_read;
    assign remote_pld_avmm_write     = r_remote_write;
    assign remote_pld_avmm_request   = r_remote_request;
    assign remote_pld_avmm_reg_addr  = r_remote_addr;
    assign remote_pld_avmm_writedata = r_remote_wdata;
    assign pld_avmm2_readdatavalid   = r_rdv;
    assign pld_avmm2_readdata        = r_rdata;

endmodule

// File: tb/tb_c3aibadapt_avmm2_initiator.sv
// ---------------------------------------------------------------------------
// tb_c3aibadapt_avmm2_initiator
//
// Directed bench for the AVMM2 initiator. The far side is driven by hand, one
// cycle at a time. Inputs change 1 time unit after a rising edge, and outputs
// are checked 1 unit later, well away from the next edge. Cycle C0 is the
// cycle in which a command is presented to the DUT.
// ---------------------------------------------------------------------------
module tb_c3aibadapt_avmm2_initiator;

    logic       clk;
    logic       rst_n;
    logic       pld_read;
    logic       pld_write;
    logic [8:0] pld_addr;
    logic [7:0] pld_wdata;
    logic       pld_waitreq;
    logic [7:0] pld_rdata;
    logic       pld_rdv;
    logic       pld_timeout;
    logic       rem_read;
    logic       rem_write;
    logic       rem_request;
    logic [8:0] rem_addr;
    logic [7:0] rem_wdata;
    logic       rem_busy;
    logic [7:0] rem_rdata;
    logic       rem_rdv;

    int total = 0;
    int bad   = 0;

    c3aibadapt_avmm2_initiator #(
        .WR_SETTLE      (2),
        .TIMEOUT_CYCLES (8),
        .ERR_DATA       (8'hEE)
    ) dut (
        .avmm_clock_dprio_clk          (clk),
        .avmm_reset_avmm_rst_n         (rst_n),
        .pld_avmm2_read                (pld_read),
        .pld_avmm2_write               (pld_write),
        .pld_avmm2_reg_addr            (pld_addr),
        .pld_avmm2_writedata           (pld_wdata),
        .pld_avmm2_waitrequest         (pld_waitreq),
        .pld_avmm2_readdata            (pld_rdata),
        .pld_avmm2_readdatavalid       (pld_rdv),
        .pld_avmm2_timeout             (pld_timeout),
        .remote_pld_avmm_read          (rem_read),
        .remote_pld_avmm_write         (rem_write),
        .remote_pld_avmm_request       (rem_request),
        .remote_pld_avmm_reg_addr      (rem_addr),
        .remote_pld_avmm_writedata     (rem_wdata),
        .remote_pld_avmm_busy          (rem_busy),
        .remote_pld_avmm_readdata      (rem_rdata),
        .remote_pld_avmm_readdatavalid (rem_rdv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        pld_read  = 1'b0;
        pld_write = 1'b0;
        pld_addr  = '0;
        pld_wdata = '0;
        rem_busy  = 1'b0;
        rem_rdata = '0;
        rem_rdv   = 1'b0;

        // ---------------- reset state ----------------
        #2;
        check("rst_waitreq",  32'(pld_waitreq), 0);
        check("rst_rem_read", 32'(rem_read),    0);
        check("rst_rem_wr",   32'(rem_write),   0);
        check("rst_rem_req",  32'(rem_request), 0);
        check("rst_rdv",      32'(pld_rdv),     0);
        check("rst_rdata",    32'(pld_rdata),   0);
        check("rst_timeout",  32'(pld_timeout), 0);
        check("rst_addr",     32'(rem_addr),    0);
        check("rst_wdata",    32'(rem_wdata),   0);
        rem_busy = 1'b1;
        #1;
        check("rst_waitreq_busy", 32'(pld_waitreq), 1);
        rem_busy = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // ---------------- T1: read 1A5 -> 3C, 6-cycle return ----------------
        pld_read = 1'b1; pld_addr = 9'h1A5;                       // C0
        #1;
        check("t1_accept_waitreq", 32'(pld_waitreq), 0);
        cyc(); pld_read = 1'b0; pld_addr = '0; #1;                // C1
        check("t1_rem_read",  32'(rem_read),    1);
        check("t1_rem_req",   32'(rem_request), 1);
        check("t1_rem_wr",    32'(rem_write),   0);
        check("t1_rem_addr",  32'(rem_addr),    32'h1A5);
        check("t1_waitreq_c1", 32'(pld_waitreq), 1);
        for (int i = 2; i <= 4; i++) begin                        // C2..C4
            cyc(); #1;
            check($sformatf("t1_rem_read_c%0d", i), 32'(rem_read),    0);
            check($sformatf("t1_rem_req_c%0d", i),  32'(rem_request), 0);
            check($sformatf("t1_waitreq_c%0d", i),  32'(pld_waitreq), 1);
            check($sformatf("t1_rdv_c%0d", i),      32'(pld_rdv),     0);
        end
        cyc(); rem_rdv = 1'b1; rem_rdata = 8'h3C; #1;             // C5
        check("t1_waitreq_c5", 32'(pld_waitreq), 1);
        check("t1_rdv_c5",     32'(pld_rdv),     0);
        cyc(); rem_rdv = 1'b0; rem_rdata = '0; #1;                // C6
        check("t1_rdv_c6",     32'(pld_rdv),     1);
        check("t1_rdata_c6",   32'(pld_rdata),   32'h3C);
        check("t1_waitreq_c6", 32'(pld_waitreq), 0);
        cyc(); #1;                                                // C7
        check("t1_rdv_c7",   32'(pld_rdv),   0);
        check("t1_rdata_c7", 32'(pld_rdata), 32'h3C);

        // ---------------- T2: write 5A to 003, busy high 5 cycles -------------
        pld_write = 1'b1; pld_addr = 9'h003; pld_wdata = 8'h5A;   // C0
        cyc(); pld_write = 1'b0; pld_addr = '0; pld_wdata = '0; #1; // C1
        check("t2_rem_wr",    32'(rem_write),   1);
        check("t2_rem_req",   32'(rem_request), 1);
        check("t2_rem_read",  32'(rem_read),    0);
        check("t2_rem_wdata", 32'(rem_wdata),   32'h5A);
        check("t2_rem_addr",  32'(rem_addr),    32'h003);
        for (int i = 2; i <= 6; i++) begin                        // C2..C6
            cyc(); rem_busy = 1'b1; #1;
            check($sformatf("t2_waitreq_c%0d", i), 32'(pld_waitreq), 1);
            check($sformatf("t2_rem_wr_c%0d", i),  32'(rem_write),   0);
            check($sformatf("t2_rdv_c%0d", i),     32'(pld_rdv),     0);
        end
        cyc(); rem_busy = 1'b0; #1;                               // C7
        check("t2_waitreq_c7", 32'(pld_waitreq), 1);
        cyc(); #1;                                                // C8
        check("t2_waitreq_c8", 32'(pld_waitreq), 0);
        check("t2_rdv_c8",     32'(pld_rdv),     0);

        // ---------------- T2b: write with no busy, settle window -------------
        pld_write = 1'b1; pld_addr = 9'h0C0; pld_wdata = 8'hA5;   // C0
        cyc(); pld_write = 1'b0; #1;                              // C1
        check("t2b_rem_wdata", 32'(rem_wdata), 32'hA5);
        for (int i = 2; i <= 4; i++) begin                        // C2..C4
            cyc(); #1;
            check($sformatf("t2b_waitreq_c%0d", i), 32'(pld_waitreq), 1);
        end
        cyc(); #1;                                                // C5
        check("t2b_waitreq_c5", 32'(pld_waitreq), 0);

        // ---------------- T3: busy in IDLE blocks accept ----------------
        rem_busy = 1'b1; pld_read = 1'b1; pld_addr = 9'h044;      // C0
        #1;
        check("t3_waitreq_busy", 32'(pld_waitreq), 1);
        cyc(); #1;                                                // C1
        check("t3_no_accept_c1", 32'(rem_read),    0);
        check("t3_waitreq_c1",   32'(pld_waitreq), 1);
        cyc(); rem_busy = 1'b0; #1;                               // C2
        check("t3_waitreq_c2",   32'(pld_waitreq), 0);
        check("t3_no_accept_c2", 32'(rem_read),    0);
        cyc(); pld_read = 1'b0; #1;                               // C3
        check("t3_rem_read", 32'(rem_read), 1);
        check("t3_rem_addr", 32'(rem_addr), 32'h044);
        cyc(); rem_rdv = 1'b1; rem_rdata = 8'h81;                 // C4
        cyc(); rem_rdv = 1'b0; #1;                                // C5
        check("t3_rdv",   32'(pld_rdv),   1);
        check("t3_rdata", 32'(pld_rdata), 32'h81);

        // ---------------- T4: read and write together -> read only ------------
        pld_read = 1'b1; pld_write = 1'b1; pld_addr = 9'h0FF; pld_wdata = 8'h11;
        cyc(); pld_read = 1'b0; pld_write = 1'b0; #1;             // C1
        check("t4_rem_read", 32'(rem_read),    1);
        check("t4_rem_wr",   32'(rem_write),   0);
        check("t4_rem_req",  32'(rem_request), 1);
        cyc(); rem_rdv = 1'b1; rem_rdata = 8'h77; #1;             // C2
        check("t4_rem_wr_c2", 32'(rem_write), 0);
        cyc(); rem_rdv = 1'b0; #1;                                // C3
        check("t4_rdv",   32'(pld_rdv),   1);
        check("t4_rdata", 32'(pld_rdata), 32'h77);
        // A stray remote valid while IDLE must be ignored.
        rem_rdv = 1'b1; rem_rdata = 8'h99;
        cyc(); rem_rdv = 1'b0; rem_rdata = '0; #1;                // C4
        check("t4_stray_rdv",   32'(pld_rdv),   0);
        check("t4_stray_rdata", 32'(pld_rdata), 32'h77);

        // ---------------- T5: reset in WAIT_RDV ----------------
        pld_read = 1'b1; pld_addr = 9'h010;                       // C0
        cyc(); pld_read = 1'b0; #1;                               // C1
        check("t5_rem_read", 32'(rem_read), 1);
        cyc();                                                    // C2 (WAIT_RDV)
        cyc(); rst_n = 1'b0; #1;                                  // C3
        check("t5_rst_rem_read", 32'(rem_read),    0);
        check("t5_rst_rem_req",  32'(rem_request), 0);
        check("t5_rst_rdv",      32'(pld_rdv),     0);
        check("t5_rst_timeout",  32'(pld_timeout), 0);
        check("t5_rst_waitreq",  32'(pld_waitreq), 0);
        check("t5_rst_addr",     32'(rem_addr),    0);
        check("t5_rst_rdata",    32'(pld_rdata),   0);
        rst_n = 1'b1;
        cyc(); rem_rdv = 1'b1; rem_rdata = 8'h42;                 // C4 late valid
        cyc(); rem_rdv = 1'b0; rem_rdata = '0; #1;                // C5
        check("t5_late_rdv",   32'(pld_rdv),   0);
        check("t5_late_rdata", 32'(pld_rdata), 0);
        pld_read = 1'b1; pld_addr = 9'h1FF; #1;
        check("t5_post_waitreq", 32'(pld_waitreq), 0);
        cyc(); pld_read = 1'b0; #1;                               // C6
        check("t5_post_rem_read", 32'(rem_read), 1);
        check("t5_post_rem_addr", 32'(rem_addr), 32'h1FF);
        cyc(); rem_rdv = 1'b1; rem_rdata = 8'hC3;                 // C7
        cyc(); rem_rdv = 1'b0; #1;                                // C8
        check("t5_post_rdv",   32'(pld_rdv),   1);
        check("t5_post_rdata", 32'(pld_rdata), 32'hC3);

`ifdef C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN
        // ---------------- T6: silent far side -> timeout ----------------
        pld_read = 1'b1; pld_addr = 9'h055;                       // C0
        cyc(); pld_read = 1'b0; #1;                               // C1
        check("t6_rem_read", 32'(rem_read), 1);
        for (int i = 2; i <= 9; i++) begin                        // 8 wait cycles
            cyc(); #1;
            check($sformatf("t6_to_c%0d", i),  32'(pld_timeout), 0);
            check($sformatf("t6_rdv_c%0d", i), 32'(pld_rdv),     0);
            check($sformatf("t6_wr_c%0d", i),  32'(pld_waitreq), 1);
        end
        cyc(); #1;                                                // C10
        check("t6_timeout", 32'(pld_timeout), 1);
        check("t6_rdv",     32'(pld_rdv),     1);
        check("t6_rdata",   32'(pld_rdata),   32'hEE);
        check("t6_waitreq", 32'(pld_waitreq), 0);
        pld_write = 1'b1; pld_addr = 9'h0AA; pld_wdata = 8'h3E;
        cyc(); pld_write = 1'b0; #1;                              // C11
        check("t6_to_clear",  32'(pld_timeout), 0);
        check("t6_rdv_clear", 32'(pld_rdv),     0);
        check("t6_next_wr",   32'(rem_write),   1);
        check("t6_next_data", 32'(rem_wdata),   32'h3E);
        for (int i = 0; i < 4; i++) cyc();
        #1;
        check("t6_next_done", 32'(pld_waitreq), 0);
`endif

        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c3aibadapt_avmm2_initiator.md
Name: c3aibadapt_avmm2_initiator

Overview:
- Initiator end of the remote AVMM2 config path. It sits on the fabric/PLD side and turns local Avalon-MM style reads and writes into single-cycle remote_pld_avmm_* request pulses toward the far-side config bridge.
- It watches remote busy and readdatavalid, returns read data to the local master, and holds off new commands with waitrequest.
- Only one transaction is outstanding at a time.

Parameters:
- WR_SETTLE, 2: cycles after a write pulse before remote busy is sampled for completion (1..15).
- TIMEOUT_CYCLES, 255: maximum cycles spent waiting in WAIT_BUSY or WAIT_RDV (1..255). Used only with the optional feature.
- ERR_DATA, 8'hEE: read data returned on a timed-out read.

Ports:
- avmm_clock_dprio_clk  in  1  Single block clock.
- avmm_reset_avmm_rst_n  in  1  Asynchronous, active-low reset.
- pld_avmm2_read  in  1  Local read command.
- pld_avmm2_write  in  1  Local write command.
- pld_avmm2_reg_addr  in  9  Local register address.
- pld_avmm2_writedata  in  8  Local write data.
- pld_avmm2_waitrequest  out  1  High = command not accepted.
- pld_avmm2_readdata  out  8  Returned read data.
- pld_avmm2_readdatavalid  out  1  One-cycle read-return strobe.
- pld_avmm2_timeout  out  1  One-cycle timeout strobe (tied 0 without the optional feature).
- remote_pld_avmm_read  out  1  Remote read pulse.
- remote_pld_avmm_write  out  1  Remote write pulse.
- remote_pld_avmm_request  out  1  Remote request pulse.
- remote_pld_avmm_reg_addr  out  9  Latched address.
- remote_pld_avmm_writedata  out  8  Latched write data.
- remote_pld_avmm_busy  in  1  Far side busy.
- remote_pld_avmm_readdata  in  8  Far side read data.
- remote_pld_avmm_readdatavalid  in  1  Far side read-return strobe.

Behaviour:
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_RDV. Reset state is IDLE.
- Reset values:
  - All registered outputs are 0; latched address and data are 0.
  - pld_avmm2_waitrequest is combinational: (state != IDLE) | remote_pld_avmm_busy. During reset it therefore follows remote busy.
- Accept rule:
  - A command is accepted in IDLE on a rising edge where (read | write) & !waitrequest.
  - On accept, address and writedata are latched and the state moves to ISSUE.
  - If read and write are both high, read wins and the write is dropped.
- ISSUE (exactly 1 cycle):
  - remote_pld_avmm_request = 1, plus remote_pld_avmm_read or remote_pld_avmm_write = 1 according to the latched type. All three outputs are registered.
  - Read goes to WAIT_RDV; write goes to WAIT_BUSY.
  - Pulses are strictly one cycle. The far side counts read-high cycles, so a wider pulse would produce duplicate returns.
- WAIT_BUSY:
  - A settle counter runs from 0 to WR_SETTLE-1 and ignores busy meanwhile.
  - Afterwards, the first cycle with busy = 0 returns the state to IDLE.
- WAIT_RDV:
  - The first cycle with remote_pld_avmm_readdatavalid = 1 captures remote_pld_avmm_readdata.
  - The next cycle gives pld_avmm2_readdatavalid = 1 for one cycle with the captured data, and the state returns to IDLE.
  - pld_avmm2_readdata holds its last value until the next return.
  - A remote readdatavalid in any other state is ignored.
- Latency:
  - Remote read pulse is 1 cycle after accept.
  - Local readdatavalid is 1 cycle after remote readdatavalid.
  - With a far side returning valid 4 cycles after the read pulse, accept-to-local-valid is 6 cycles.
- Back-to-back commands: the earliest re-accept is the cycle the state is IDLE again. There is no queuing.
- Reset mid-transaction: the state is forced to IDLE, strobes clear, and the outstanding transaction is abandoned with no local return.

Optional Feature:
- Macro: C3AIBADAPT_AVMM2_INIT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT_BUSY or WAIT_RDV and increments each cycle there.
  - When it reaches TIMEOUT_CYCLES, the state goes to IDLE and pld_avmm2_timeout pulses for 1 cycle.
  - A timed-out read also pulses pld_avmm2_readdatavalid in that same cycle with ERR_DATA.
  - If the remote valid and the timeout coincide, the valid wins and no timeout is reported.
- Undefined: no counter; WAIT states wait indefinitely; pld_avmm2_timeout is tied to 0.

Test Plan:
- Read at addr 9'h1A5, far-side model returns 8'h3C 4 cycles after the read pulse -> remote read/request high exactly 1 cycle with addr 9'h1A5; local readdatavalid 6 cycles after accept with data 8'h3C; waitrequest high in between.
- Write 8'h5A to 9'h003, busy held high 5 cycles after the pulse -> remote write 1 cycle with data 8'h5A; waitrequest released the cycle after busy falls; no readdatavalid.
- remote_pld_avmm_busy = 1 while IDLE, read held high -> no accept; accept occurs on the first edge after busy = 0.
- Read and write both high -> only a remote read pulse; no remote write.
- Reset asserted in WAIT_RDV -> all strobes 0, state IDLE; a late remote valid causes no local return.
- Macro defined, TIMEOUT_CYCLES = 8, far side silent on a read -> timeout and readdatavalid pulse together with data 8'hEE; next command is accepted.
